// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO sequencing arbiter.
//   - arb_state_e : controller states (idle, write, read, capture)
//   - NREQ_DEF/DW_DEF : default requester count and data width
//   - FIFO_DEPTH/FIFO_CAP : shift-register FIFO depth and usable capacity
//   - STAT_W : width of the optional statistics counters
//   - ptr_w() : width of an index into NREQ requesters
package fifo_arb_pkg;

    localparam int unsigned NREQ_DEF   = 4;
    localparam int unsigned DW_DEF     = 8;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned FIFO_CAP   = FIFO_DEPTH - 1;
    localparam int unsigned STAT_W     = 16;

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StRd,
        StCap
    } arb_state_e;

    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_arbiter_if.sv
// fifo_arbiter_if: producer/consumer handshake and FIFO strobe bundle.
//   Producer side : wr_req[NREQ], wr_data[NREQ*DW], wr_gnt[NREQ]
//   Consumer side : rd_req, rd_valid, rd_data[DW]
//   FIFO side     : fifo_en, fifo_rd, fifo_wr, fifo_din[DW], fifo_dout[DW],
//                   fifo_full_n, fifo_empty_n (active-low flags)
// Modports: master = the arbiter, slave = producers/consumer/FIFO around it.
interface fifo_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned DW   = DW_DEF
) ();

    logic [NREQ-1:0]    wr_req;
    logic [NREQ*DW-1:0] wr_data;
    logic [NREQ-1:0]    wr_gnt;
    logic               rd_req;
    logic               rd_valid;
    logic [DW-1:0]      rd_data;
    logic               fifo_en;
    logic               fifo_rd;
    logic               fifo_wr;
    logic [DW-1:0]      fifo_din;
    logic [DW-1:0]      fifo_dout;
    logic               fifo_full_n;
    logic               fifo_empty_n;

    modport master (
        input  wr_req, wr_data, rd_req, fifo_dout, fifo_full_n, fifo_empty_n,
        output wr_gnt, rd_valid, rd_data, fifo_en, fifo_rd, fifo_wr, fifo_din
    );

    modport slave (
        output wr_req, wr_data, rd_req, fifo_dout, fifo_full_n, fifo_empty_n,
        input  wr_gnt, rd_valid, rd_data, fifo_en, fifo_rd, fifo_wr, fifo_din
    );

endinterface

// File: rtl/fifo_arbiter_rr_pick.sv
// fifo_arbiter_rr_pick: combinational round-robin requester picker.
//   req[NREQ] : request vector
//   ptr[PW]   : index where the search starts
//   gnt[NREQ] : one-hot of the first request found at or after ptr (wrapping)
//   idx[PW]   : binary index of that request
//   any       : at least one request is present
module fifo_arbiter_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned PW   = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            any
);

    logic [PW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = PW'((32'(ptr) + k) % NREQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_arbiter.sv
// fifo_arbiter: sequences NREQ producers and one consumer onto a single
// shift-register FIFO. Never issues read and write together; writers are served
// round-robin and reads alternate with writes when both are eligible.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : fifo_arbiter_if.master (request/grant, read data, FIFO strobes)
// Optional feature macro FIFO_ARB_STATS_EN adds:
//   stat_wr_cnt, stat_rd_cnt : saturating counts of wr_gnt / rd_valid pulses
module fifo_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    fifo_arbiter_if.master    bus
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_wr_cnt,
    output logic [STAT_W-1:0] stat_rd_cnt
`endif
);

    localparam int unsigned PW = ptr_w(NREQ);

    arb_state_e      state_q;
    logic [PW-1:0]   rr_ptr_q;
    logic            last_rd_q;

    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic [DW-1:0]   pick_data;
    logic            wr_ok;
    logic            rd_ok;
    logic            go_rd;
    logic            go_wr;

    fifo_arbiter_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req (bus.wr_req),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        pick_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                pick_data = bus.wr_data[i*DW +: DW];
            end
        end
        wr_ok = pick_any & bus.fifo_full_n;
        rd_ok = bus.rd_req & bus.fifo_empty_n;
        // When both are eligible the type not served last wins.
        go_rd = rd_ok & (~wr_ok | ~last_rd_q);
        go_wr = wr_ok & ~go_rd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            last_rd_q    <= 1'b0;
            bus.wr_gnt   <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            bus.fifo_en  <= 1'b0;
            bus.fifo_rd  <= 1'b0;
            bus.fifo_wr  <= 1'b0;
            bus.fifo_din <= '0;
        end else begin
            // Strobes and pulses are single-cycle unless set below.
            bus.wr_gnt   <= '0;
            bus.rd_valid <= 1'b0;
            bus.fifo_en  <= 1'b0;
            bus.fifo_rd  <= 1'b0;
            bus.fifo_wr  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (go_rd) begin
                        state_q     <= StRd;
                        bus.fifo_en <= 1'b1;
                        bus.fifo_rd <= 1'b1;
                        last_rd_q   <= 1'b1;
                    end else if (go_wr) begin
                        state_q      <= StWr;
                        bus.fifo_en  <= 1'b1;
                        bus.fifo_wr  <= 1'b1;
                        bus.fifo_din <= pick_data;
                        bus.wr_gnt   <= pick_gnt;
                        last_rd_q    <= 1'b0;
                        rr_ptr_q     <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
                    end
                end
                StWr:    state_q <= StIdle;
                StRd:    state_q <= StCap;
                StCap: begin
                    // FIFO output register updated on the RD edge; capture it now.
                    bus.rd_data  <= bus.fifo_dout;
                    bus.rd_valid <= 1'b1;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] stat_wr_q;
    logic [STAT_W-1:0] stat_rd_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_wr_q <= '0;
            stat_rd_q <= '0;
        end else begin
            if ((|bus.wr_gnt) && (stat_wr_q != '1)) begin
                stat_wr_q <= stat_wr_q + STAT_W'(1);
            end
            if (bus.rd_valid && (stat_rd_q != '1)) begin
                stat_rd_q <= stat_rd_q + STAT_W'(1);
            end
        end
    end

    assign stat_wr_cnt = stat_wr_q;
    assign stat_rd_cnt = stat_rd_q;
`endif

endmodule

// File: tb/tb_fifo_arbiter.sv
// tb_fifo_arbiter: self-checking bench for fifo_arbiter with a behavioural
// 16-entry shift-register FIFO and a grant/read-data scoreboard.
module tb_fifo_arbiter;
    import fifo_arb_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned BUDGET = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fifo_rst_n = 1'b0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] stat_wr_cnt;
    logic [STAT_W-1:0] stat_rd_cnt;
`endif

    fifo_arbiter #(
        .NREQ (NREQ),
        .DW   (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_wr_cnt (stat_wr_cnt),
        .stat_rd_cnt (stat_rd_cnt)
`endif
    );

    // Behavioural FIFO driven only by the arbiter strobes.
    logic [DW-1:0] mem [FIFO_DEPTH];
    int unsigned   fcount;
    logic [DW-1:0] fdout;

    always @(posedge clk or negedge fifo_rst_n) begin
        if (!fifo_rst_n) begin
            fcount <= 0;
            fdout  <= '0;
        end else if (bus.fifo_en) begin
            if (bus.fifo_wr && fcount < FIFO_CAP) begin
                mem[fcount[AW-1:0]] <= bus.fifo_din;
                fcount <= fcount + 1;
            end else if (bus.fifo_rd && fcount != 0) begin
                fdout <= mem[0];
                for (int i = 0; i < FIFO_DEPTH - 1; i++) mem[i] <= mem[i+1];
                fcount <= fcount - 1;
            end
        end
    end

    assign bus.fifo_dout    = fdout;
    assign bus.fifo_full_n  = (fcount < FIFO_CAP);
    assign bus.fifo_empty_n = (fcount != 0);

    logic [DW-1:0] pdata [NREQ];
    always_comb begin
        bus.wr_data = '0;
        for (int i = 0; i < NREQ; i++) bus.wr_data[i*DW +: DW] = pdata[i];
    end

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard
    logic [NREQ-1:0] exp_gnt [$];
    logic [DW-1:0]   exp_rd [$];
    logic [NREQ-1:0] g;
    int unsigned n_gnt = 0, n_rv = 0, n_frd = 0;
    int unsigned gnt_cyc = 0, rv_cyc = 0, prev_gnt_cyc = 0;
    bit chk_gap = 1'b0, gap_armed = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            check("rd_wr_excl", 32'(bus.fifo_rd & bus.fifo_wr), 32'd0);
            if (bus.fifo_rd) n_frd++;
            if (bus.wr_gnt != '0) begin
                n_gnt++;
                if (exp_gnt.size() == 0) begin
                    check("gnt_unexp", 32'(bus.wr_gnt), 32'd0);
                end else begin
                    g = exp_gnt.pop_front();
                    check("gnt_order", 32'(bus.wr_gnt), 32'(g));
                    check("gnt_strobe", 32'({bus.fifo_en, bus.fifo_wr, bus.fifo_rd}), 32'b110);
                    for (int i = 0; i < NREQ; i++) begin
                        if (g[i]) begin
                            check("fifo_din", 32'(bus.fifo_din), 32'(pdata[i]));
                            exp_rd.push_back(pdata[i]);
                        end
                    end
                end
                if (chk_gap && gap_armed) check("gnt_gap", cyc - prev_gnt_cyc, 32'd2);
                gap_armed    = 1'b1;
                prev_gnt_cyc = cyc;
                gnt_cyc      = cyc;
            end
            if (bus.rd_valid) begin
                n_rv++;
                rv_cyc = cyc;
                if (exp_rd.size() == 0) check("rd_unexp", 32'(bus.rd_valid), 32'd0);
                else check("rd_data", 32'(bus.rd_data), 32'(exp_rd.pop_front()));
            end
        end
    end

    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_gnts(input int unsigned target, input string tag);
        int unsigned k = 0;
        while (n_gnt < target && k < BUDGET) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (n_gnt < target) check(tag, n_gnt, target);
    endtask

    task automatic wait_rv(input int unsigned target, input string tag);
        int unsigned k = 0;
        while (n_rv < target && k < BUDGET) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (n_rv < target) check(tag, n_rv, target);
    endtask

    task automatic drain(input string tag);
        int unsigned k = 0;
        bus.rd_req = 1'b1;
        while (exp_rd.size() != 0 && k < BUDGET) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (exp_rd.size() != 0) check(tag, exp_rd.size(), 32'd0);
        bus.rd_req = 1'b0;
        cycles(4);
    endtask

    task automatic chk_outputs_zero(input string pfx);
        check({pfx, "_gnt"},  32'(bus.wr_gnt),   32'd0);
        check({pfx, "_rv"},   32'(bus.rd_valid), 32'd0);
        check({pfx, "_rdat"}, 32'(bus.rd_data),  32'd0);
        check({pfx, "_en"},   32'(bus.fifo_en),  32'd0);
        check({pfx, "_rd"},   32'(bus.fifo_rd),  32'd0);
        check({pfx, "_wr"},   32'(bus.fifo_wr),  32'd0);
        check({pfx, "_din"},  32'(bus.fifo_din), 32'd0);
    endtask

    initial begin
        repeat ((1 << STAT_W) / 4) @(posedge clk);
        check("watchdog", cyc, 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] oh;
        int unsigned base, base_rv, frd0, start, k;

        bus.wr_req = '0;
        bus.rd_req = 1'b0;
        pdata = '{8'h10, 8'h21, 8'h32, 8'h43};
        cycles(2);
        chk_outputs_zero("reset");
        rst = 1'b1;
        fifo_rst_n = 1'b1;
        cycles(2);

        // Round-robin over all four producers, one grant per two cycles.
        for (int i = 0; i < 5; i++) begin
            oh = 4'b0001;
            oh = oh << (i % 4);
            exp_gnt.push_back(oh);
        end
        chk_gap = 1'b1;
        gap_armed = 1'b0;
        base = n_gnt;
        bus.wr_req = 4'b1111;
        wait_gnts(base + 5, "to_rr");
        bus.wr_req = '0;
        chk_gap = 1'b0;
        cycles(4);
        check("rr_count", n_gnt - base, 32'd5);
        drain("to_drain_rr");

        // Fill to capacity, then one read frees a slot for the waiting writer.
        pdata[0] = 8'h5A;
        repeat (FIFO_CAP) exp_gnt.push_back(4'b0001);
        base = n_gnt;
        bus.wr_req = 4'b0001;
        wait_gnts(base + FIFO_CAP, "to_fill");
        cycles(10);
        check("full_flag", 32'(bus.fifo_full_n), 32'd0);
        check("full_no_gnt", n_gnt - base, FIFO_CAP);
        exp_gnt.push_back(4'b0001);
        base_rv = n_rv;
        bus.rd_req = 1'b1;
        wait_rv(base_rv + 1, "to_full_rd");
        bus.rd_req = 1'b0;
        wait_gnts(base + FIFO_CAP + 1, "to_refill");
        check("refill_gap", gnt_cyc - rv_cyc, 32'd1);
        bus.wr_req = '0;
        cycles(3);
        check("full_again", 32'(bus.fifo_full_n), 32'd0);
        drain("to_drain_full");

        // Alternation: FIFO holds 0x11, 0x22; read and write pending together.
        pdata[1] = 8'h11;
        exp_gnt.push_back(4'b0010);
        base = n_gnt;
        bus.wr_req = 4'b0010;
        wait_gnts(base + 1, "to_alt_w1");
        bus.wr_req = '0;
        pdata[1] = 8'h22;
        exp_gnt.push_back(4'b0010);
        bus.wr_req = 4'b0010;
        wait_gnts(base + 2, "to_alt_w2");
        bus.wr_req = '0;
        cycles(2);
        pdata[2] = 8'hA5;
        exp_gnt.push_back(4'b0100);
        base = n_gnt;
        base_rv = n_rv;
        start = cyc;
        bus.rd_req = 1'b1;
        bus.wr_req = 4'b0100;
        wait_gnts(base + 1, "to_alt");
        bus.wr_req = '0;
        check("alt_rd_lat", rv_cyc - start, 32'd3);
        check("alt_gnt_lat", gnt_cyc - start, 32'd4);
        check("alt_rd_first", n_rv - base_rv, 32'd1);
        drain("to_drain_alt");

        // Read request against an empty FIFO waits for a write.
        base_rv = n_rv;
        frd0 = n_frd;
        bus.rd_req = 1'b1;
        cycles(8);
        check("empty_no_rd", n_frd - frd0, 32'd0);
        check("empty_no_rv", n_rv - base_rv, 32'd0);
        pdata[3] = 8'h3C;
        exp_gnt.push_back(4'b1000);
        base = n_gnt;
        bus.wr_req = 4'b1000;
        wait_gnts(base + 1, "to_empty_w");
        bus.wr_req = '0;
        wait_rv(base_rv + 1, "to_empty_rv");
        bus.rd_req = 1'b0;
        cycles(2);
        check("empty_rd_data", 32'(bus.rd_data), 32'h3C);

        // Reset during RD: outputs clear at once, pointer returns to 0.
        pdata[2] = 8'h77;
        exp_gnt.push_back(4'b0100);
        base = n_gnt;
        bus.wr_req = 4'b0100;
        wait_gnts(base + 1, "to_rst_w");
        bus.wr_req = '0;
        cycles(2);
        base_rv = n_rv;
        bus.rd_req = 1'b1;
        k = 0;
        while (!bus.fifo_rd && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("rst_saw_rd", 32'(bus.fifo_rd), 32'd1);
        rst = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        bus.rd_req = 1'b0;
        cycles(2);
        rst = 1'b1;
        cycles(6);
        check("rst_no_rv", n_rv - base_rv, 32'd0);
        exp_gnt.push_back(4'b0001);
        base = n_gnt;
        bus.wr_req = 4'b1111;
        wait_gnts(base + 1, "to_rst_rr");
        bus.wr_req = '0;
        cycles(2);
        drain("to_drain_rst");

`ifdef FIFO_ARB_STATS_EN
        rst = 1'b0;
        cycles(1);
        rst = 1'b1;
        cycles(1);
        repeat (3) exp_gnt.push_back(4'b0010);
        base = n_gnt;
        bus.wr_req = 4'b0010;
        wait_gnts(base + 3, "to_st_w");
        bus.wr_req = '0;
        base_rv = n_rv;
        bus.rd_req = 1'b1;
        wait_rv(base_rv + 2, "to_st_r");
        bus.rd_req = 1'b0;
        cycles(4);
        check("stat_wr", 32'(stat_wr_cnt), 32'd3);
        check("stat_rd", 32'(stat_rd_cnt), 32'd2);
        force dut.stat_wr_q = 16'hFFFE;
        #1;
        release dut.stat_wr_q;
        repeat (3) exp_gnt.push_back(4'b0010);
        base = n_gnt;
        bus.wr_req = 4'b0010;
        wait_gnts(base + 2, "to_sat_w");
        cycles(1);
        check("stat_sat", 32'(stat_wr_cnt), 32'hFFFF);
        wait_gnts(base + 3, "to_sat_w3");
        bus.wr_req = '0;
        cycles(2);
        check("stat_hold", 32'(stat_wr_cnt), 32'hFFFF);
        drain("to_drain_st");
`endif

        check("gnt_q_left", exp_gnt.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
